// File: rtl/resv_issue_ctrl_if.sv
// Control-side bundle for one reservation station: decoder handshake,
// per-cell candidate codes, execution-pipe handshakes and the cell
// control strobes. The master modport is the control stage itself;
// the slave modport is the decoder, cells and execution units.
interface resv_issue_ctrl_if #(
   parameter int W_ident = 4,
   parameter int N_cell  = 8,
   parameter int W_cnt   = 4
);
   logic                        flush;
   logic [N_cell*W_ident-1:0]   candit0_bus;
   logic [N_cell*W_ident-1:0]   candit1_bus;
   logic                        dec_valid;
   logic                        dec_ready;
   logic                        exe0_ready;
   logic                        exe1_ready;
   logic                        exe0_valid;
   logic                        exe1_valid;
   logic [W_ident-1:0]          issue_sel;
   logic [W_ident-1:0]          addr_insert;
   logic [W_ident-1:0]          addr_shift;
   logic                        cell_clear;
   logic [W_cnt-1:0]            count;
   logic                        full;
   logic                        empty;

   modport master (
      input  flush, candit0_bus, candit1_bus, dec_valid, exe0_ready, exe1_ready,
      output dec_ready, exe0_valid, exe1_valid, issue_sel, addr_insert,
             addr_shift, cell_clear, count, full, empty
   );

   modport slave (
      output flush, candit0_bus, candit1_bus, dec_valid, exe0_ready, exe1_ready,
      input  dec_ready, exe0_valid, exe1_valid, issue_sel, addr_insert,
             addr_shift, cell_clear, count, full, empty
   );
endinterface

// File: rtl/resv_issue_ctrl.sv
// Issue control for an 8-entry compacting reservation station.
// Tracks occupancy, picks the oldest ready entry for pipe 0/1 (pipe 0
// wins a tie at the same index) and drives insert/shift/clear to cells.
// Optional macro RESV_ISSUE_PERF_EN adds 32-bit performance counters.
module resv_issue_ctrl #(
   parameter int W_ident = 4,
   parameter int N_cell  = 8,
   parameter int W_cnt   = 4
) (
   input  logic                   clk,
   input  logic                   clear_n,
`ifdef RESV_ISSUE_PERF_EN
   output logic [31:0]            perf_issue,
   output logic [31:0]            perf_full_stall,
   output logic [31:0]            perf_ready_idle,
`endif
   resv_issue_ctrl_if.master      bus
);
   localparam logic [W_ident-1:0] unused_cd = {W_ident{1'b1}};

   logic [W_cnt-1:0]   r_count;
   logic               w_full;
   logic               w_ins;
   logic               w_iss;
   logic               w_found;
   logic               w_pipe1;
   logic [W_ident-1:0] w_idx;
   logic [N_cell-1:0]  w_pick0;
   logic [N_cell-1:0]  w_pick1;

   assign w_full         = (r_count == W_cnt'(N_cell));
   assign bus.full       = w_full;
   assign bus.empty      = (r_count == '0);
   assign bus.count      = r_count;
   assign bus.dec_ready  = ~w_full;
   assign bus.cell_clear = ~clear_n | bus.flush;

   // Reset is treated like a flush so nothing is inserted or issued
   // while the cells are being cleared.
   assign w_ins = bus.dec_valid & ~w_full & ~bus.flush & clear_n;

   // Per-cell candidate qualification: code must name the cell itself
   // and the cell must hold a valid entry; mismatches and unused_cd drop out.
   generate
      for (genvar gi = 0; gi < N_cell; gi++) begin : g_cand
         logic w_live;
         assign w_live      = (W_cnt'(gi) < r_count);
         assign w_pick0[gi] = w_live & bus.exe0_ready &
                              (bus.candit0_bus[gi*W_ident +: W_ident] == W_ident'(gi));
         assign w_pick1[gi] = w_live & bus.exe1_ready &
                              (bus.candit1_bus[gi*W_ident +: W_ident] == W_ident'(gi));
      end
   endgenerate

   // Oldest-first select: scan downwards so the lowest hit is kept last.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_pipe1 = 1'b0;
      for (int i = N_cell - 1; i >= 0; i--) begin
         if (w_pick0[i] | w_pick1[i]) begin
            w_found = 1'b1;
            w_idx   = W_ident'(i);
            w_pipe1 = ~w_pick0[i];
         end
      end
   end

   assign w_iss          = w_found & ~bus.flush & clear_n;
   assign bus.exe0_valid = w_iss & ~w_pipe1;
   assign bus.exe1_valid = w_iss & w_pipe1;
   assign bus.issue_sel  = w_iss ? w_idx : unused_cd;
   assign bus.addr_shift = w_iss ? w_idx : unused_cd;

   // Insert slot: when an issue compacts the array the top slot frees up,
   // so the new op lands one lower; the cell's insert priority wins there.
   always_comb begin
      bus.addr_insert = unused_cd;
      if (w_ins & ~w_iss)
         bus.addr_insert = W_ident'(r_count);
      else if (w_ins & w_iss)
         bus.addr_insert = W_ident'(r_count - W_cnt'(1));
   end

   // Occupancy counter; reset and flush both empty the station.
   always_ff @(posedge clk) begin
      if (!clear_n || bus.flush)
         r_count <= '0;
      else
         r_count <= r_count + W_cnt'(w_ins) - W_cnt'(w_iss);
   end

   // Occupancy invariant check.
   always_ff @(posedge clk) begin
      if (clear_n)
         assert (r_count <= W_cnt'(N_cell))
            else $error("resv_issue_ctrl: count exceeds N_cell");
   end

`ifdef RESV_ISSUE_PERF_EN
   logic [31:0] r_perf_issue;
   logic [31:0] r_perf_full_stall;
   logic [31:0] r_perf_ready_idle;

   // Performance counters; cleared only by reset, not by flush.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         r_perf_issue      <= '0;
         r_perf_full_stall <= '0;
         r_perf_ready_idle <= '0;
      end else begin
         if (w_iss)
            r_perf_issue <= r_perf_issue + 32'd1;
         if (bus.dec_valid & w_full)
            r_perf_full_stall <= r_perf_full_stall + 32'd1;
         if ((r_count != '0) & ~w_iss & (bus.exe0_ready | bus.exe1_ready))
            r_perf_ready_idle <= r_perf_ready_idle + 32'd1;
      end
   end

   assign perf_issue      = r_perf_issue;
   assign perf_full_stall = r_perf_full_stall;
   assign perf_ready_idle = r_perf_ready_idle;
`endif
endmodule

// File: tb/tb_resv_issue_ctrl.sv
// Directed-vector bench for resv_issue_ctrl with hand-computed expectations.
module tb_resv_issue_ctrl;
   localparam int W = 4;
   localparam int N = 8;
   localparam logic [3:0] UNU = 4'hF;

   logic clk;
   logic clear_n;
   logic [3:0] c0 [N];
   logic [3:0] c1 [N];
   int n_vec;
   int n_miss;
   int exp_cnt;

`ifdef RESV_ISSUE_PERF_EN
   logic [31:0] perf_issue, perf_full_stall, perf_ready_idle;
`endif

   resv_issue_ctrl_if #(.W_ident(W), .N_cell(N), .W_cnt(4)) rs ();

   resv_issue_ctrl #(.W_ident(W), .N_cell(N), .W_cnt(4)) dut (
      .clk             (clk),
      .clear_n         (clear_n),
`ifdef RESV_ISSUE_PERF_EN
      .perf_issue      (perf_issue),
      .perf_full_stall (perf_full_stall),
      .perf_ready_idle (perf_ready_idle),
`endif
      .bus             (rs.master)
   );

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pack
         assign rs.candit0_bus[gi*W +: W] = c0[gi];
         assign rs.candit1_bus[gi*W +: W] = c1[gi];
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_cands();
      for (int i = 0; i < N; i++) begin
         c0[i] = UNU;
         c1[i] = UNU;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Insert n ops with no candidates present.
   task automatic do_ins(input int n);
      for (int k = 0; k < n; k++) begin
         rs.dec_valid = 1'b1;
         #1;
         check_eq("ins_addr", 32'(rs.addr_insert), 32'(exp_cnt));
         check_eq("ins_noiss", 32'(rs.exe0_valid | rs.exe1_valid), 0);
         tick();
         exp_cnt++;
         check_eq("ins_count", 32'(rs.count), 32'(exp_cnt));
      end
      rs.dec_valid = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_miss = 0; exp_cnt = 0;
      clr_cands();
      clear_n = 1'b0;
      rs.flush = 1'b0;
      rs.dec_valid = 1'b0;
      rs.exe0_ready = 1'b1;
      rs.exe1_ready = 1'b1;
      #1;
      // Reset state
      check_eq("rst_clear", 32'(rs.cell_clear), 1);
      check_eq("rst_exe0", 32'(rs.exe0_valid), 0);
      check_eq("rst_exe1", 32'(rs.exe1_valid), 0);
      check_eq("rst_sel", 32'(rs.issue_sel), 32'(UNU));
      check_eq("rst_ins", 32'(rs.addr_insert), 32'(UNU));
      check_eq("rst_shift", 32'(rs.addr_shift), 32'(UNU));
      tick();
      check_eq("rst_count", 32'(rs.count), 0);
      check_eq("rst_empty", 32'(rs.empty), 1);
      check_eq("rst_full", 32'(rs.full), 0);
      check_eq("rst_ready", 32'(rs.dec_ready), 1);
      clear_n = 1'b1;
      #1;
      check_eq("run_clear", 32'(rs.cell_clear), 0);

      // Three inserts -> slots 0,1,2
      do_ins(3);

      // Oldest ready: cell1 pipe0 beats cell2 pipe1
      c0[1] = 4'd1; c1[2] = 4'd2;
      #1;
      check_eq("old_sel", 32'(rs.issue_sel), 1);
      check_eq("old_exe0", 32'(rs.exe0_valid), 1);
      check_eq("old_exe1", 32'(rs.exe1_valid), 0);
      check_eq("old_shift", 32'(rs.addr_shift), 1);
      check_eq("old_ins", 32'(rs.addr_insert), 32'(UNU));
      tick(); exp_cnt = 2;
      check_eq("old_count", 32'(rs.count), 2);
      clr_cands();

      // count=4: cell0 pipe1 blocked, cell2 mismatched, cell3 pipe0 ready
      do_ins(2);
      c1[0] = 4'd0; c0[2] = 4'd1; c0[3] = 4'd3;
      rs.exe1_ready = 1'b0;
      #1;
      check_eq("blk_sel", 32'(rs.issue_sel), 3);
      check_eq("blk_exe0", 32'(rs.exe0_valid), 1);
      check_eq("blk_exe1", 32'(rs.exe1_valid), 0);
      check_eq("blk_shift", 32'(rs.addr_shift), 3);
      tick(); exp_cnt = 3;
      check_eq("blk_count", 32'(rs.count), 3);
      clr_cands();
      rs.exe1_ready = 1'b1;

      // Candidate above count is ignored
      c0[5] = 4'd5;
      #1;
      check_eq("oob_exe0", 32'(rs.exe0_valid), 0);
      check_eq("oob_shift", 32'(rs.addr_shift), 32'(UNU));
      tick();
      check_eq("oob_count", 32'(rs.count), 3);
      clr_cands();

      // Tie at index 0: pipe 0 wins
      c0[0] = 4'd0; c1[0] = 4'd0;
      #1;
      check_eq("tie_exe0", 32'(rs.exe0_valid), 1);
      check_eq("tie_exe1", 32'(rs.exe1_valid), 0);
      check_eq("tie_sel", 32'(rs.issue_sel), 0);
      tick(); exp_cnt = 2;
      clr_cands();

      // Lower-index pipe1 beats higher-index pipe0
      c1[0] = 4'd0; c0[1] = 4'd1;
      #1;
      check_eq("p1_exe1", 32'(rs.exe1_valid), 1);
      check_eq("p1_exe0", 32'(rs.exe0_valid), 0);
      check_eq("p1_sel", 32'(rs.issue_sel), 0);
      tick(); exp_cnt = 1;
      check_eq("p1_count", 32'(rs.count), 1);
      clr_cands();

      // Fill to 8
      do_ins(7);
      check_eq("fill_full", 32'(rs.full), 1);
      check_eq("fill_ready", 32'(rs.dec_ready), 0);
      check_eq("fill_empty", 32'(rs.empty), 0);
      rs.dec_valid = 1'b1; c0[5] = 4'd5;
      #1;
      check_eq("full_ins", 32'(rs.addr_insert), 32'(UNU));
      check_eq("full_shift", 32'(rs.addr_shift), 5);
      check_eq("full_exe0", 32'(rs.exe0_valid), 1);
      tick(); exp_cnt = 7;
      check_eq("full_count", 32'(rs.count), 7);
      rs.dec_valid = 1'b0;
      clr_cands();

      // Drain to 5, then insert and issue together
      c0[0] = 4'd0;
      tick();
      check_eq("drn_count6", 32'(rs.count), 6);
      tick();
      check_eq("drn_count5", 32'(rs.count), 5);
      clr_cands();
      rs.dec_valid = 1'b1; c0[2] = 4'd2;
      #1;
      check_eq("both_ins", 32'(rs.addr_insert), 4);
      check_eq("both_shift", 32'(rs.addr_shift), 2);
      tick(); exp_cnt = 5;
      check_eq("both_count", 32'(rs.count), 5);
      rs.dec_valid = 1'b0;
      clr_cands();

      // count=6, flush outranks insert and issue
      do_ins(1);
      rs.flush = 1'b1; rs.dec_valid = 1'b1; c0[0] = 4'd0;
      #1;
      check_eq("fl_clear", 32'(rs.cell_clear), 1);
      check_eq("fl_exe0", 32'(rs.exe0_valid), 0);
      check_eq("fl_ins", 32'(rs.addr_insert), 32'(UNU));
      check_eq("fl_shift", 32'(rs.addr_shift), 32'(UNU));
      tick(); exp_cnt = 0;
      check_eq("fl_count", 32'(rs.count), 0);
      check_eq("fl_empty", 32'(rs.empty), 1);
      rs.flush = 1'b0;

      // Insert latency: op with ready code is not issued in its insert cycle
      #1;
      check_eq("lat_ins", 32'(rs.addr_insert), 0);
      check_eq("lat_noiss", 32'(rs.exe0_valid), 0);
      tick(); exp_cnt = 1;
      rs.dec_valid = 1'b0;
      #1;
      check_eq("lat_exe0", 32'(rs.exe0_valid), 1);
      check_eq("lat_sel", 32'(rs.issue_sel), 0);
      tick(); exp_cnt = 0;
      check_eq("lat_count", 32'(rs.count), 0);

      // Empty: matching codes everywhere, still no issue
      for (int i = 0; i < N; i++) begin
         c0[i] = 4'(i);
         c1[i] = 4'(i);
      end
      #1;
      check_eq("emp_exe0", 32'(rs.exe0_valid), 0);
      check_eq("emp_exe1", 32'(rs.exe1_valid), 0);
      check_eq("emp_shift", 32'(rs.addr_shift), 32'(UNU));
      tick();
      check_eq("emp_count", 32'(rs.count), 32'(exp_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
